// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and slicing helpers for the multi-port
// register file and its pending-write scoreboard.
package regfile_pkg;

  // Architectural zero register address.
  localparam int ZERO_ADDR  = 0;

  // Default geometry of the MIPS integer register file.
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Low bit index of lane 'lane' inside a flattened vector of 'width'-bit lanes.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

  // Number of registers addressed by an 'addr_w'-bit address.
  function automatic int depth_of(input int addr_w);
    return 32'sd1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one busy bit per register tracking in-flight producers.
// A reservation from decode marks a register busy; a writeback to it releases
// it. When both hit the same register in one cycle the reservation wins,
// since the newly issued producer supersedes the one retiring.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int NUM_RD      = 2,
  parameter int NUM_WR      = 1,
  parameter int ZERO_REG_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  input  logic [NUM_WR-1:0]        wen,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [NUM_RD-1:0]        rbusy,
  output logic                     any_busy
);

  localparam int              DEPTH   = depth_of(ADDR_W);
  localparam logic            ZERO_ON = (ZERO_REG_EN != 0);
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);

  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic [ADDR_W-1:0] w_raddr [NUM_RD];
  logic [ADDR_W-1:0] w_waddr [NUM_WR];
  logic              w_rsv_ok;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_unpack
    assign w_raddr[i] = raddr[lane_lo(i, ADDR_W) +: ADDR_W];
  end

  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr_unpack
    assign w_waddr[j] = waddr[lane_lo(j, ADDR_W) +: ADDR_W];
  end

  // The zero register can never become busy, so a reservation of it is ignored.
  assign w_rsv_ok = rsv_en & ~(ZERO_ON & (rsv_addr == ZERO_A));

  // Next busy state: release every written register, then apply the reservation on top.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int j = 0; j < NUM_WR; j++) begin
      w_busy_nxt[w_waddr[j]] = w_busy_nxt[w_waddr[j]] & ~wen[j];
    end
    w_busy_nxt[rsv_addr] = w_busy_nxt[rsv_addr] | w_rsv_ok;
  end

  // Busy-bit storage; reset drops every outstanding reservation at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rbusy
    assign rbusy[i] = r_busy[w_raddr[i]] & ~(ZERO_ON & (w_raddr[i] == ZERO_A));
  end

  assign any_busy = |r_busy;

endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: parametrised multi-port register file with a hardwired zero
// register, asynchronous clear and a pending-write scoreboard for RAW hazard
// detection in decode.
//
// Build option: define REGFILE_BYPASS_EN to forward same-cycle writes to the
// read ports (zero-cycle read-after-write). Without it reads return the
// contents held before the clock edge and RAW latency is one cycle.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int NUM_RD      = 2,
  parameter int NUM_WR      = 1,
  parameter int ZERO_REG_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic [NUM_WR-1:0]        wen,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     any_busy
);

  localparam int                DEPTH   = depth_of(ADDR_W);
  localparam logic              ZERO_ON = (ZERO_REG_EN != 0);
  localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(ZERO_ADDR);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] w_raddr [NUM_RD];
  logic [ADDR_W-1:0] w_waddr [NUM_WR];
  logic [DATA_W-1:0] w_wdata [NUM_WR];
  logic [NUM_WR-1:0] w_wr_ok;
  logic [NUM_RD-1:0] w_sb_rbusy;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_unpack
    assign w_raddr[i] = raddr[lane_lo(i, ADDR_W) +: ADDR_W];
  end

  // A write to the zero register is dropped here so neither storage nor bypass sees it.
  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr_unpack
    assign w_waddr[j] = waddr[lane_lo(j, ADDR_W) +: ADDR_W];
    assign w_wdata[j] = wdata[lane_lo(j, DATA_W) +: DATA_W];
    assign w_wr_ok[j] = wen[j] & ~(ZERO_ON & (w_waddr[j] == ZERO_A));
  end

  // Data storage; ports are applied in ascending order so the highest port wins a clash.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (w_wr_ok[j]) begin
          r_mem[w_waddr[j]] <= w_wdata[j];
        end
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W      (ADDR_W),
    .NUM_RD      (NUM_RD),
    .NUM_WR      (NUM_WR),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .raddr    (raddr),
    .wen      (wen),
    .waddr    (waddr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rbusy    (w_sb_rbusy),
    .any_busy (any_busy)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [DATA_W-1:0] w_rd_val;
    logic [DATA_W-1:0] w_rd_out;
`ifdef REGFILE_BYPASS_EN
    logic              w_fwd_hit;
    logic              w_rsv_same;

    // Forward any same-cycle write to this port, later write ports taking priority.
    always_comb begin
      w_rd_val  = r_mem[w_raddr[i]];
      w_fwd_hit = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
        w_rd_val  = (w_wr_ok[j] && (w_waddr[j] == w_raddr[i])) ? w_wdata[j] : w_rd_val;
        w_fwd_hit = w_fwd_hit | (w_wr_ok[j] & (w_waddr[j] == w_raddr[i]));
      end
    end

    // A forwarded write retires the producer now, unless a new producer claims the register.
    assign w_rsv_same = rsv_en & (rsv_addr == w_raddr[i]);
    assign rbusy[i]   = w_fwd_hit ? w_rsv_same : w_sb_rbusy[i];
`else
    // Reads see only the contents held before the coming clock edge.
    always_comb begin
      w_rd_val = r_mem[w_raddr[i]];
    end

    assign rbusy[i] = w_sb_rbusy[i];
`endif

    // The zero register always reads as zero regardless of storage contents.
    always_comb begin
      if (ZERO_ON && (w_raddr[i] == ZERO_A)) begin
        w_rd_out = '0;
      end else begin
        w_rd_out = w_rd_val;
      end
    end

    assign rdata[lane_lo(i, DATA_W) +: DATA_W] = w_rd_out;
  end

endmodule
